// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit; optional MULDIV_FAST_SPECIAL_EN short-circuits trivial cases.
// Latency: XLEN+1 cycles from start edge to done (1 cycle for fast special cases when enabled).
// Backpressure: start is ignored while busy (no queuing); flush aborts without a done pulse.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_raw;
    logic [XLEN-1:0]   opa;     // multiplicand, or dividend/quotient shift register
    logic [XLEN-1:0]   opb;     // multiplier shift register, or divisor
    logic [XLEN-1:0]   acc;     // product high half, or partial remainder
    logic [CNT_W-1:0]  cnt;
    logic              a_neg_q;
    logic              b_neg_q;
    logic              dz_q;
    logic              ovf_q;

    logic              a_sgn_in;
    logic              b_sgn_in;
    logic [XLEN-1:0]   a_mag_in;
    logic [XLEN-1:0]   b_mag_in;
    logic              ovf_in;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mul_res;

    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem_n;
    logic [XLEN-1:0]   div_q_n;
    logic [XLEN-1:0]   div_res;

    logic              last_iter;

    function automatic logic [XLEN-1:0] special_val(input logic [2:0]      f,
                                                    input logic [XLEN-1:0] dividend,
                                                    input logic            by_zero);
        logic [XLEN-1:0] v;
        v = '0;
        if (f[2]) begin
            if (by_zero)
                v = f[1] ? dividend : '1;
            else
                v = f[1] ? '0 : dividend;
        end
        return v;
    endfunction

    always_comb begin
        a_sgn_in = a[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM));
        b_sgn_in = b[XLEN-1] & ((op == OP_MULH) | (op == OP_DIV) | (op == OP_REM));
        a_mag_in = a_sgn_in ? (~a + 1'b1) : a;
        b_mag_in = b_sgn_in ? (~b + 1'b1) : b;
        ovf_in   = ((op == OP_DIV) | (op == OP_REM)) & (a == MOST_NEG) & (b == '1);
    end

    // Shift-add: conditionally add the multiplicand into the high half, then shift the whole product right.
    always_comb begin
        mul_sum  = {1'b0, acc} + (opb[0] ? {1'b0, opa} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, opb[XLEN-1:1]};
        mul_prod = (a_neg_q ^ b_neg_q) ? (~mul_next + 1'b1) : mul_next;
        mul_res  = (op_q[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    // Restoring step: the remainder is always below the divisor, so the trial fits in XLEN+1 bits.
    always_comb begin
        div_shift = {acc, opa[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_ge    = ~div_diff[XLEN];
        div_rem_n = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_q_n   = {opa[XLEN-2:0], div_ge};
        if (op_q[1])
            div_res = a_neg_q ? (~div_rem_n + 1'b1) : div_rem_n;
        else
            div_res = (a_neg_q ^ b_neg_q) ? (~div_q_n + 1'b1) : div_q_n;
    end

    assign last_iter = (cnt == CNT_W'(XLEN-1));

`ifdef MULDIV_FAST_SPECIAL_EN
    logic fast_hit;
    assign fast_hit = op[2] ? ((b == '0) | ovf_in) : ((a == '0) | (b == '0));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            done    <= 1'b0;
            result  <= '0;
            op_q    <= '0;
            a_raw   <= '0;
            opa     <= '0;
            opb     <= '0;
            acc     <= '0;
            cnt     <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            op_q    <= op;
                            a_raw   <= a;
                            opa     <= a_mag_in;
                            opb     <= b_mag_in;
                            acc     <= '0;
                            cnt     <= '0;
                            a_neg_q <= a_sgn_in;
                            b_neg_q <= b_sgn_in;
                            dz_q    <= (b == '0);
                            ovf_q   <= ovf_in;
`ifdef MULDIV_FAST_SPECIAL_EN
                            if (fast_hit) begin
                                state  <= DONE;
                                done   <= 1'b1;
                                result <= special_val(op, a, (b == '0));
                            end else begin
                                state <= op[2] ? DIV : MUL;
                            end
`else
                            state <= op[2] ? DIV : MUL;
`endif
                        end
                    end
                    MUL: begin
                        {acc, opb} <= mul_next;
                        cnt        <= cnt + 1'b1;
                        if (last_iter) begin
                            result <= mul_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    DIV: begin
                        acc <= div_rem_n;
                        opa <= div_q_n;
                        cnt <= cnt + 1'b1;
                        if (last_iter) begin
                            result <= (dz_q | ovf_q) ? special_val(op_q, a_raw, dz_q) : div_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit.
- Sits directly downstream of the ALU B-operand/immediate mux in the EX stage and consumes its B output alongside the A operand.
- Accepts one operation per start pulse, holds the pipeline through busy, and returns a registered result with a one-cycle done pulse.
- Radix-2: one result bit per cycle, so datapath size stays small.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a new operation; sampled only in IDLE
- flush  input  1  abort any in-flight operation (pipeline flush)
- op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  rs1 operand
- b  input  XLEN  operand from the B-operand mux
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; result valid this cycle
- result  output  XLEN  registered result; holds its value until the next completion

Behaviour:
- Reset: rst_n low at a clock edge sets state=IDLE, busy=0, done=0, result=0. Reset overrides everything, including mid-operation; the in-flight operation is lost.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 at edge (cycle 0) latches op, a, b.
  - Signed ops store operand magnitudes plus sign flags; count resets to 0.
  - Next state is MUL for op[2]=0, DIV for op[2]=1.
- MUL:
  - Unsigned shift-add over the 2*XLEN product, one multiplier bit per cycle.
  - Cycles 1..XLEN, then DONE.
- DIV:
  - Restoring division, one quotient bit per cycle.
  - Cycles 1..XLEN, then DONE.
- DONE (cycle XLEN+1):
  - done=1 and result is updated on entry to DONE.
  - Next state is IDLE, so a new start can be accepted in cycle XLEN+2.
- Latency: the start edge to done is XLEN+1 cycles (33 at default). busy is high cycles 1..XLEN+1.
- start while busy: ignored, with no queuing; the operand inputs are not re-sampled.
- flush=1 at any edge:
  - state goes to IDLE and done stays 0; result is unchanged.
  - flush has priority over start in the same cycle.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU: both unsigned.
  - MUL: returns the low XLEN bits.
  - MULH*: return the high XLEN bits of the 2*XLEN product.
  - Product is negated at the end when the operand signs differ.
  - DIV/REM: signed; the quotient is negated when the signs differ, and the remainder takes the dividend's sign.
- Special cases (RISC-V-mandated results):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a = most-negative value, b = -1): DIV gives a, REM gives 0.
  - In the base build, special cases still run the full XLEN+1 latency with the forced result.

Optional Feature:
- Macro: MULDIV_FAST_SPECIAL_EN.
- Defined:
  - In IDLE, a divide-by-zero, signed overflow, or MUL-family op with a==0 or b==0 goes directly to DONE.
  - done is asserted in cycle 1; busy is high in cycle 1 only.
  - The result is the mandated special value, or 0 for a zero-operand multiply.
- Undefined:
  - All operations take fixed XLEN+1 latency.
  - The special-case detection logic is removed except for the result forcing needed for the DIV/REM special values.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; done in cycle 33 only; busy high in cycles 1..33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
  - Without the macro: done in cycle 33.
  - With MULDIV_FAST_SPECIAL_EN: done in cycle 1.
- Start DIVU, pulse start with new operands in cycle 5 (ignored), flush in cycle 10 -> busy=0 in cycle 11, no done pulse, result keeps its prior value.
  - A new start in cycle 11 completes normally in cycle 44.
- Start MUL, assert rst_n=0 in cycle 20 -> at the next edge busy=0, done=0, result=0; no done pulse afterwards.
